// File: rtl/spi_master_interface.sv
// SPI mode 0 master: one full-duplex MSB-first word per start request, with sck
// divided down from valid_clk and cs framing that includes setup, hold and idle gaps.
module spi_master_interface #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic                  valid_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD,
    GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   data_received_q, data_received_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;

  // Each timed state runs for N cycles and leaves on the edge where cnt_q == N-1.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_cnt_d       = bit_cnt_q;
    tx_shift_d      = tx_shift_q;
    rx_shift_d      = rx_shift_q;
    data_received_d = data_received_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    cs_d            = cs_q;
    sck_d           = sck_q;
    mosi_d          = mosi_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = data_to_send;
          mosi_d     = data_to_send[DATA_WIDTH-1];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = SCK_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCK_LO: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
          cnt_d      = '0;
          state_d    = SCK_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCK_HI: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          cnt_d     = '0;
          if ((bit_cnt_q + 1'b1) < BIT_W'(DATA_WIDTH)) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d     = tx_shift_q[DATA_WIDTH-2];
            state_d    = SCK_LO;
          end else begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cs_d            = 1'b1;
          data_received_d = rx_shift_q;
          done_d          = 1'b1;
          cnt_d           = '0;
          state_d         = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge valid_clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      tx_shift_q      <= '0;
      rx_shift_q      <= '0;
      data_received_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cs_q            <= 1'b1;
      sck_q           <= 1'b0;
      mosi_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      tx_shift_q      <= tx_shift_d;
      rx_shift_q      <= rx_shift_d;
      data_received_q <= data_received_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cs_q            <= cs_d;
      sck_q           <= sck_d;
      mosi_q          <= mosi_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign data_received = data_received_q;
  assign cs            = cs_q;
  assign sck           = sck_q;
  assign mosi          = mosi_q;

endmodule

// File: tb/tb_spi_master_interface.sv
// Directed bench for spi_master_interface (DATA_WIDTH=16, CLK_DIV=2, CS_SETUP/HOLD/IDLE=2)
// with loopback, constant-miso and behavioural mode-0 slave miso sources.
module tb_spi_master_interface;

  localparam int DW = 16;

  logic          valid_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic [DW-1:0] data_to_send = '0;
  logic          busy, done, cs, sck, mosi, miso;
  logic [DW-1:0] data_received;

  // miso source: 0 = constant miso_val, 1 = loopback from mosi, 2 = slave model
  int unsigned   miso_mode = 0;
  logic          miso_val  = 1'b0;
  logic          s_miso    = 1'b0;
  logic [DW-1:0] s_tx = '0, s_rx = '0, s_synced = '0;

  int vectors = 0, miscompares = 0;
  int cyc = 0, e0 = 0;
  int sck_pulses = 0, done_cnt = 0, sck_while_cs_high = 0;
  logic mosi_seen_high = 1'b0;

  assign miso = (miso_mode == 1) ? mosi : (miso_mode == 2) ? s_miso : miso_val;

  spi_master_interface #(
    .DATA_WIDTH(16),
    .CLK_DIV   (2),
    .CS_SETUP  (2),
    .CS_HOLD   (2),
    .CS_IDLE   (2)
  ) dut (
    .valid_clk    (valid_clk),
    .reset        (reset),
    .start        (start),
    .data_to_send (data_to_send),
    .busy         (busy),
    .done         (done),
    .data_received(data_received),
    .cs           (cs),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso)
  );

  always #5 valid_clk = ~valid_clk;

  always @(posedge valid_clk) cyc <= cyc + 1;
  always @(posedge sck) sck_pulses <= sck_pulses + 1;
  always @(negedge valid_clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (cs && sck) sck_while_cs_high <= sck_while_cs_high + 1;
    if (mosi) mosi_seen_high <= 1'b1;
  end

  // Mode-0 slave: loads its word on cs fall, samples mosi on sck rise, shifts on sck fall.
  always @(negedge cs) if (miso_mode == 2) begin s_tx = 16'h3C5A; s_miso = s_tx[DW-1]; end
  always @(posedge sck) if (miso_mode == 2) s_rx = {s_rx[DW-2:0], mosi};
  always @(negedge sck) if (miso_mode == 2) begin s_tx = s_tx << 1; s_miso = s_tx[DW-1]; end
  always @(posedge cs) if (miso_mode == 2) s_synced = s_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge and record that edge's cycle number as E0.
  task automatic launch(input logic [DW-1:0] word);
    @(negedge valid_clk);
    start = 1'b1;
    data_to_send = word;
    @(posedge valid_clk);
    #1 e0 = cyc;
    @(negedge valid_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge valid_clk);
      #1;
      if (done) begin lat = cyc - e0; break; end
    end
  endtask

  task automatic wait_idle(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge valid_clk);
      #1;
      if (!busy) begin lat = cyc - e0; break; end
    end
  endtask

  initial begin
    int lat, dc0, gap;

    // Reset state
    repeat (3) @(negedge valid_clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", data_received, 0);
    reset = 1'b0;
    repeat (2) @(negedge valid_clk);

    // 1: loopback 0xA5C3, done at E0+68, busy low at E0+70
    miso_mode = 1;
    sck_pulses = 0;
    dc0 = done_cnt;
    launch(16'hA5C3);
    check("t1_cs_low", cs, 0);
    check("t1_busy", busy, 1);
    wait_done(lat);
    check("t1_done_lat", lat, 68);
    check("t1_rx", data_received, 16'hA5C3);
    check("t1_cs_high_at_done", cs, 1);
    check("t1_sck_pulses", sck_pulses, 16);
    wait_idle(lat);
    check("t1_busy_lat", lat, 70);
    check("t1_done_count", done_cnt - dc0, 1);

    // 2: miso=1 with 0x0000 sent, then miso=0
    miso_mode = 0;
    miso_val = 1'b1;
    mosi_seen_high = 1'b0;
    launch(16'h0000);
    wait_done(lat);
    check("t2_rx_ones", data_received, 16'hFFFF);
    check("t2_mosi_quiet", mosi_seen_high, 0);
    wait_idle(lat);
    miso_val = 1'b0;
    launch(16'h0000);
    wait_done(lat);
    check("t2_rx_zeros", data_received, 16'h0000);
    wait_idle(lat);

    // 3: start mid-frame is ignored
    miso_mode = 1;
    dc0 = done_cnt;
    launch(16'h5AF0);
    repeat (20) @(negedge valid_clk);
    start = 1'b1;
    data_to_send = 16'h1234;
    @(negedge valid_clk);
    start = 1'b0;
    wait_done(lat);
    check("t3_done_lat", lat, 68);
    check("t3_rx", data_received, 16'h5AF0);
    wait_idle(lat);
    repeat (80) @(negedge valid_clk);
    check("t3_no_queue_busy", busy, 0);
    check("t3_done_count", done_cnt - dc0, 1);

    // 4: reset at E0+30 abandons the frame
    dc0 = done_cnt;
    launch(16'h1111);
    while (cyc < e0 + 30) @(posedge valid_clk);
    #1 reset = 1'b1;
    #1;
    check("t4_cs", cs, 1);
    check("t4_sck", sck, 0);
    check("t4_busy", busy, 0);
    repeat (3) @(negedge valid_clk);
    reset = 1'b0;
    repeat (80) @(negedge valid_clk);
    check("t4_no_done", done_cnt - dc0, 0);
    check("t4_rx_cleared", data_received, 0);
    launch(16'h9C3E);
    wait_done(lat);
    check("t4_after_lat", lat, 68);
    check("t4_after_rx", data_received, 16'h9C3E);
    wait_idle(lat);

    // 5: start held high -> back-to-back frames; cs rises with done and falls on the
    // accept edge one cycle after busy drops, so the cs-high stretch spans CS_IDLE+1 cycles
    @(negedge valid_clk);
    data_to_send = 16'h8001;
    start = 1'b1;
    @(posedge valid_clk);
    #1 e0 = cyc;
    wait_done(lat);
    check("t5_f1_lat", lat, 68);
    check("t5_f1_rx", data_received, 16'h8001);
    sck_pulses = 0;
    gap = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge valid_clk);
      if (!cs) break;
      gap++;
    end
    check("t5_cs_gap", gap, 3);
    check("t5_gap_no_sck", sck_pulses, 0);
    e0 = e0 + 71;
    wait_done(lat);
    check("t5_f2_lat", lat, 68);
    check("t5_f2_rx", data_received, 16'h8001);
    start = 1'b0;
    wait_idle(lat);
    repeat (4) @(negedge valid_clk);
    check("t5_idle_after", busy, 0);
    check("t5_no_sck_cs_high", sck_while_cs_high, 0);

    // 6: against a mode-0 slave holding 0x3C5A
    miso_mode = 2;
    s_rx = '0;
    launch(16'hBEEF);
    wait_done(lat);
    check("t6_master_rx", data_received, 16'h3C5A);
    @(negedge valid_clk);
    check("t6_slave_rx", s_synced, 16'hBEEF);
    wait_idle(lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
